tx_port_bank: RTL

TX_PORT_BANK -- requirements
Module: tx_port_bank

---
 rtl/tx_port_bank.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tx_port_bank.sv
// tx_port_bank -- routes a single input word stream to NUM_CH independent
// output streams, each buffered by its own DEPTH-word FIFO.
//
// Optional feature: define TX_PORT_BANK_EXC_EN to make `exception` a sticky
// flag that sets when a word with an out-of-range channel index is accepted.
// Without it, `exception` is tied to 0. In both builds, such words are
// acknowledged and dropped.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous reset, active low
//   input_cmd      [DATA_W]         word to forward
//   input_cmd_sel  [SEL_W]          destination channel index
//   input_cmd_stb / input_cmd_ack   input handshake
//   output_ch      [NUM_CH*DATA_W]  channel k head word at [k*DATA_W +: DATA_W]
//   output_ch_stb  [NUM_CH]         channel k has data
//   output_ch_ack  [NUM_CH]         channel k sink accepts
//   exception                       sticky out-of-range flag

// Per-channel FIFO. The storage array is not reset because the head word is
// only meaningful while the FIFO is non-empty.
module tx_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              vld,
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign vld   = |cnt;
  assign full  = (cnt == FULL_CNT);
endmodule

module tx_port_bank #(
  parameter  int NUM_CH = 5,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        input_cmd,
  input  logic [SEL_W-1:0]         input_cmd_sel,
  input  logic                     input_cmd_stb,
  output logic                     input_cmd_ack,
  output logic [NUM_CH*DATA_W-1:0] output_ch,
  output logic [NUM_CH-1:0]        output_ch_stb,
  input  logic [NUM_CH-1:0]        output_ch_ack,
  output logic                     exception
);
  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] push, pop, full;
  logic              sel_ok, sel_full, accept;

  // Decode the destination without indexing past NUM_CH when sel is out of
  // range; an out-of-range index never looks full.
  always_comb begin
    sel_ok   = ({1'b0, input_cmd_sel} < NUM_CH_L);
    sel_full = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (input_cmd_sel == k[SEL_W-1:0]) sel_full = full[k];
  end

  // Space is judged on registered occupancy only, so a same-cycle pop does
  // not free a slot. Gated by rst so ack is low throughout reset.
  assign input_cmd_ack = rst & input_cmd_stb & (~sel_ok | ~sel_full);
  assign accept        = input_cmd_stb & input_cmd_ack;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      push[k] = accept & sel_ok & (input_cmd_sel == k[SEL_W-1:0]);
  end

  assign pop = output_ch_stb & output_ch_ack;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tx_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .wdata (input_cmd),
      .pop   (pop[k]),
      .rdata (output_ch[k*DATA_W +: DATA_W]),
      .vld   (output_ch_stb[k]),
      .full  (full[k])
    );
  end

`ifdef TX_PORT_BANK_EXC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   exception <= 1'b0;
    else if (accept && !sel_ok) exception <= 1'b1;
  end
`else
  assign exception = 1'b0;
`endif
endmodule
